// File: rtl/led_frame_controller_pkg.sv
// ============================================================================
// Package : led_pkg
// Desc    : Shared geometry, frame types and helpers for the LED frame controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package led_pkg;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int ROW_W = $clog2(ROWS);

    typedef logic [COLS-1:0] row_t;
    typedef row_t [ROWS-1:0] frame_t;

    typedef struct packed {
        frame_t red;
        frame_t green;
    } bicolour_frame_t;

    // Prescaler width; a divider of 1 still needs a one-bit counter.
    function automatic int div_width(input int scan_div);
        int w;
        w = $clog2(scan_div);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_frame_controller_scan_prescaler.sv
// ============================================================================
// Module : scan_prescaler
// Desc   : Row-scan pacing: clk prescaler, row-advance strobe, row counter
//          and frame-boundary pulse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module scan_prescaler
    import led_pkg::*;
#(
    parameter int SCAN_DIV = 1024
) (
    input  logic             clk,
    input  logic             reset,
    output logic             scan_tick,
    output logic [ROW_W-1:0] row_idx,
    output logic             frame_start
);

    localparam int               DIV_W    = div_width(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    logic [DIV_W-1:0] div_cnt;

    // Gated by reset so a divide-by-one build stays quiet while held in reset.
    assign scan_tick   = (div_cnt == DIV_LAST) && !reset;
    assign frame_start = scan_tick && (row_idx == ROW_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            row_idx <= '0;
        end else if (scan_tick) begin
            div_cnt <= '0;
            row_idx <= row_idx + ROW_W'(1);
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/led_frame_controller.sv
// ============================================================================
// Module : led_frame_controller
// Desc   : Double-buffered 8x8 bicolour frame scheduler; swaps the back and
//          front buffers only on a frame boundary so the scan never tears.
//          Optional macro LED_FC_COPY_EN: refresh the new back buffer with the
//          just-published frame at every swap.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module led_frame_controller
    import led_pkg::*;
#(
    parameter int SCAN_DIV = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [ROW_W-1:0] wr_row,
    input  row_t             wr_red,
    input  row_t             wr_green,
    input  logic             commit,
    output logic             pending,
    output frame_t           red_array,
    output frame_t           green_array,
    output logic             scan_tick,
    output logic [ROW_W-1:0] row_idx,
    output logic             frame_start,
    output logic [7:0]       frame_count
);

    bicolour_frame_t bank [2];
    logic            front_sel;
    logic            back_sel;
    logic            wr_fire;
    logic            swap;

    scan_prescaler #(
        .SCAN_DIV    (SCAN_DIV)
    ) u_scan_prescaler (
        .clk         (clk),
        .reset       (reset),
        .scan_tick   (scan_tick),
        .row_idx     (row_idx),
        .frame_start (frame_start)
    );

    assign back_sel = ~front_sel;
    assign wr_ready = !pending && !reset;
    assign wr_fire  = wr_valid && wr_ready;
    assign swap     = frame_start && pending;

    // Front buffer is a pure mux of registers; write traffic never reaches it combinationally.
    assign red_array   = bank[front_sel].red;
    assign green_array = bank[front_sel].green;

    always_ff @(posedge clk) begin
        if (reset) begin
            bank[0]     <= '0;
            bank[1]     <= '0;
            front_sel   <= 1'b0;
            pending     <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            // Writes are only accepted while nothing is pending, so they never collide with a swap.
            if (wr_fire) begin
                bank[back_sel].red[wr_row]   <= wr_red;
                bank[back_sel].green[wr_row] <= wr_green;
            end

            if (swap) begin
                front_sel   <= back_sel;
                pending     <= 1'b0;
                frame_count <= frame_count + 8'd1;
`ifdef LED_FC_COPY_EN
                bank[front_sel] <= bank[back_sel];
`endif
            end else if (commit && !pending) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
